half_rate_generator: RTL and testbench

- Transmit-side counterpart of half-rate recovery: synthesizes a clock with independently programmed high and low half-rates, counted in `clk_en` ticks of the system clock.
- Emits single-cycle edge events in the same form the recovery path consumes as `sense_event`, so a generator can drive a recovery instance directly for loopback.
- Guarantees glitch-free start and stop: no truncated half-period is ever produced.

---
 rtl/half_rate_generator.sv | 125 ++++++++++++
 tb/tb_half_rate_generator.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/half_rate_generator.sv
// Programmable clock synthesizer: independent high/low half-rates counted in clk_en ticks,
// with registered edge-event pulses and glitch-free start/stop at period boundaries.
module half_rate_generator #(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     async_rst_n,
  input  logic                     clk_en,
  input  logic                     gen_en_i,
  input  logic                     idle_level_i,
  input  logic [COUNTER_WIDTH-1:0] high_rate_i,
  input  logic [COUNTER_WIDTH-1:0] low_rate_i,
  input  logic                     clear_error_i,
  output logic                     clk_o,
  output logic                     rise_event_o,
  output logic                     fall_event_o,
  output logic                     active_o,
  output logic                     config_error_o
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ACTIVE_PHASE = 2'd1,
    IDLE_PHASE   = 2'd2
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state, state_nxt;
  logic [COUNTER_WIDTH-1:0] counter, counter_nxt;
  logic [COUNTER_WIDTH-1:0] high_sh, high_sh_nxt;
  logic [COUNTER_WIDTH-1:0] low_sh, low_sh_nxt;
  logic [COUNTER_WIDTH-1:0] high_clamp, low_clamp;
  logic                     idle_lvl, idle_lvl_nxt;
  logic                     clk_nxt, rise_nxt, fall_nxt, err_nxt;
  logic                     start;

  assign high_clamp = (high_rate_i == '0) ? ONE : high_rate_i;
  assign low_clamp  = (low_rate_i  == '0) ? ONE : low_rate_i;
  assign active_o   = (state != IDLE);

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state          <= IDLE;
      counter        <= '0;
      high_sh        <= ONE;
      low_sh         <= ONE;
      idle_lvl       <= 1'b0;
      clk_o          <= 1'b0;
      rise_event_o   <= 1'b0;
      fall_event_o   <= 1'b0;
      config_error_o <= 1'b0;
    end else begin
      state          <= state_nxt;
      counter        <= counter_nxt;
      high_sh        <= high_sh_nxt;
      low_sh         <= low_sh_nxt;
      idle_lvl       <= idle_lvl_nxt;
      clk_o          <= clk_nxt;
      rise_event_o   <= rise_nxt;
      fall_event_o   <= fall_nxt;
      config_error_o <= err_nxt;
    end
  end

  // A period always starts from the registered idle level, so the first edge is a real toggle.
  always_comb begin
    state_nxt    = state;
    counter_nxt  = counter;
    high_sh_nxt  = high_sh;
    low_sh_nxt   = low_sh;
    idle_lvl_nxt = idle_lvl;
    clk_nxt      = clk_o;
    rise_nxt     = 1'b0;
    fall_nxt     = 1'b0;
    err_nxt      = config_error_o & ~clear_error_i;
    start        = 1'b0;

    if (clk_en) begin
      case (state)
        IDLE: begin
          if (gen_en_i) begin
            start = 1'b1;
          end else begin
            idle_lvl_nxt = idle_level_i;
            clk_nxt      = idle_level_i;
          end
        end
        ACTIVE_PHASE: begin
          if (counter == '0) begin
            state_nxt   = IDLE_PHASE;
            clk_nxt     = idle_lvl;
            counter_nxt = (idle_lvl ? high_sh : low_sh) - ONE;
            rise_nxt    = idle_lvl;
            fall_nxt    = ~idle_lvl;
          end else begin
            counter_nxt = counter - ONE;
          end
        end
        IDLE_PHASE: begin
          if (counter == '0) begin
            if (gen_en_i) start = 1'b1;
            else          state_nxt = IDLE;
          end else begin
            counter_nxt = counter - ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Set beats a simultaneous clear when a zero rate is captured.
    if (start) begin
      state_nxt   = ACTIVE_PHASE;
      high_sh_nxt = high_clamp;
      low_sh_nxt  = low_clamp;
      clk_nxt     = ~idle_lvl;
      counter_nxt = (idle_lvl ? low_clamp : high_clamp) - ONE;
      rise_nxt    = ~idle_lvl;
      fall_nxt    = idle_lvl;
      if ((high_rate_i == '0) || (low_rate_i == '0)) err_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_half_rate_generator.sv
// Bench for half_rate_generator: vector table, directed corner sequences and
// a randomized run against a queue-of-levels reference model.
module tb_half_rate_generator;

  logic        clk;
  logic        async_rst_n;
  logic        clk_en;
  logic        gen_en;
  logic        idle_level;
  logic [15:0] high_rate;
  logic [15:0] low_rate;
  logic        clear_error;
  logic        clk_out;
  logic        rise_event;
  logic        fall_event;
  logic        active;
  logic        config_error;

  int errors = 0;
  int checks = 0;

  half_rate_generator #(.COUNTER_WIDTH(16)) dut (
    .clk            (clk),
    .async_rst_n    (async_rst_n),
    .clk_en         (clk_en),
    .gen_en_i       (gen_en),
    .idle_level_i   (idle_level),
    .high_rate_i    (high_rate),
    .low_rate_i     (low_rate),
    .clear_error_i  (clear_error),
    .clk_o          (clk_out),
    .rise_event_o   (rise_event),
    .fall_event_o   (fall_event),
    .active_o       (active),
    .config_error_o (config_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic en;
    logic gen;
    logic exp_clk;
    logic exp_rise;
    logic exp_fall;
    logic exp_act;
  } vec_t;

  // Reference model: a period is a list of per-tick levels, consumed one per clk_en tick.
  logic m_run, m_lvl, m_clk, m_err, m_rise, m_fall;
  logic m_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    async_rst_n = 1'b0;
    clk_en      = 1'b0;
    gen_en      = 1'b0;
    idle_level  = 1'b0;
    high_rate   = 16'd1;
    low_rate    = 16'd1;
    clear_error = 1'b0;
    repeat (2) tick();
    async_rst_n = 1'b1;
    tick();
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_lvl = 1'b0; m_clk = 1'b0; m_err = 1'b0;
    m_rise = 1'b0; m_fall = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step();
    logic old_clk;
    logic start;
    int   ha, la, na, ni;
    old_clk = m_clk;
    start   = 1'b0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    if (clear_error) m_err = 1'b0;
    if (clk_en) begin
      if (!m_run) begin
        if (gen_en) start = 1'b1;
        else begin m_lvl = idle_level; m_clk = idle_level; end
      end else begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          if (gen_en) start = 1'b1;
          else begin m_run = 1'b0; m_clk = m_lvl; end
        end else begin
          m_clk = m_q[0];
        end
      end
      if (start) begin
        ha = (high_rate == 0) ? 1 : int'(high_rate);
        la = (low_rate == 0) ? 1 : int'(low_rate);
        na = m_lvl ? la : ha;
        ni = m_lvl ? ha : la;
        m_q.delete();
        for (int i = 0; i < na; i++) m_q.push_back(!m_lvl);
        for (int i = 0; i < ni; i++) m_q.push_back(m_lvl);
        m_run = 1'b1;
        m_clk = m_q[0];
        if (high_rate == 0 || low_rate == 0) m_err = 1'b1;
      end
      if (m_run) begin
        m_rise = m_clk & ~old_clk;
        m_fall = ~m_clk & old_clk;
      end
    end
  endtask

  // Counts consecutive cycles at level lvl (current cycle included), with optional alternating clk_en.
  task automatic measure_run(input logic lvl, input logic alt, output int n, output int ev);
    n = 0;
    ev = 0;
    while (clk_out === lvl && n < 64) begin
      n++;
      ev += int'(rise_event) + int'(fall_event);
      if (alt) clk_en = ~clk_en;
      tick();
    end
  endtask

  initial begin
    vec_t vecs[13];
    int   n, ev;

    // Reset state
    async_rst_n = 1'b0;
    clk_en = 1'b0; gen_en = 1'b0; idle_level = 1'b0;
    high_rate = 16'd1; low_rate = 16'd1; clear_error = 1'b0;
    #12;
    check_val("reset_clk", clk_out, 0);
    check_val("reset_rise", rise_event, 0);
    check_val("reset_fall", fall_event, 0);
    check_val("reset_active", active, 0);
    check_val("reset_err", config_error, 0);
    reset_dut();

    // Table: idle=0, high=3, low=2, with one clk_en=0 hold and a final stop
    vecs[0]  = '{1, 1, 1, 1, 0, 1};
    vecs[1]  = '{1, 1, 1, 0, 0, 1};
    vecs[2]  = '{0, 1, 1, 0, 0, 1};
    vecs[3]  = '{1, 1, 1, 0, 0, 1};
    vecs[4]  = '{1, 1, 0, 0, 1, 1};
    vecs[5]  = '{1, 1, 0, 0, 0, 1};
    vecs[6]  = '{1, 1, 1, 1, 0, 1};
    vecs[7]  = '{1, 1, 1, 0, 0, 1};
    vecs[8]  = '{1, 1, 1, 0, 0, 1};
    vecs[9]  = '{1, 1, 0, 0, 1, 1};
    vecs[10] = '{1, 0, 0, 0, 0, 1};
    vecs[11] = '{1, 0, 0, 0, 0, 0};
    vecs[12] = '{1, 0, 0, 0, 0, 0};
    high_rate = 16'd3; low_rate = 16'd2;
    for (int i = 0; i < 13; i++) begin
      clk_en = vecs[i].en;
      gen_en = vecs[i].gen;
      tick();
      check_val($sformatf("vec%0d_clk", i), clk_out, vecs[i].exp_clk);
      check_val($sformatf("vec%0d_rise", i), rise_event, vecs[i].exp_rise);
      check_val($sformatf("vec%0d_fall", i), fall_event, vecs[i].exp_fall);
      check_val($sformatf("vec%0d_active", i), active, vecs[i].exp_act);
    end

    // clk_en every other cycle, high=2 low=2
    reset_dut();
    high_rate = 16'd2; low_rate = 16'd2; gen_en = 1'b1; clk_en = 1'b1;
    tick();
    measure_run(1'b1, 1'b1, n, ev);
    check_val("alt_high_cycles", n, 4);
    check_val("alt_high_events", ev, 1);
    measure_run(1'b0, 1'b1, n, ev);
    check_val("alt_low_cycles", n, 4);
    check_val("alt_low_events", ev, 1);

    // High rate change in mid active phase takes effect next period
    reset_dut();
    high_rate = 16'd3; low_rate = 16'd2; gen_en = 1'b1; clk_en = 1'b1;
    tick();
    tick();
    high_rate = 16'd5;
    measure_run(1'b1, 1'b0, n, ev);
    check_val("chg_first_high", n, 2);
    measure_run(1'b0, 1'b0, n, ev);
    check_val("chg_low", n, 2);
    measure_run(1'b1, 1'b0, n, ev);
    check_val("chg_second_high", n, 5);

    // Graceful stop requested one tick into a high=4/low=2 period
    reset_dut();
    high_rate = 16'd4; low_rate = 16'd2; gen_en = 1'b1; clk_en = 1'b1;
    tick();
    gen_en = 1'b0;
    measure_run(1'b1, 1'b0, n, ev);
    check_val("stop_high", n, 4);
    n = 0;
    while (active === 1'b1 && n < 64) begin n++; tick(); end
    check_val("stop_low_active", n, 2);
    check_val("stop_clk", clk_out, 0);
    ev = 0;
    for (int i = 0; i < 10; i++) begin
      ev += int'(rise_event) + int'(fall_event) + int'(active);
      tick();
    end
    check_val("stop_quiet", ev, 0);

    // Zero high rate: clamped to one tick, sticky error until cleared
    reset_dut();
    high_rate = 16'd0; low_rate = 16'd2; gen_en = 1'b1; clk_en = 1'b1;
    tick();
    measure_run(1'b1, 1'b0, n, ev);
    check_val("zero_high", n, 1);
    check_val("zero_err_set", config_error, 1);
    high_rate = 16'd3;
    measure_run(1'b0, 1'b0, n, ev);
    check_val("zero_low", n, 2);
    check_val("zero_err_sticky", config_error, 1);
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    check_val("zero_err_clear", config_error, 0);

    // Idle level 1: first event is a fall; async reset mid-phase; clean restart
    reset_dut();
    idle_level = 1'b1; clk_en = 1'b1;
    tick();
    tick();
    check_val("idle1_clk", clk_out, 1);
    check_val("idle1_noevent", int'(rise_event) + int'(fall_event), 0);
    high_rate = 16'd2; low_rate = 16'd2; gen_en = 1'b1;
    tick();
    check_val("idle1_fall", fall_event, 1);
    check_val("idle1_rise", rise_event, 0);
    check_val("idle1_clk_low", clk_out, 0);
    tick();
    idle_level = 1'b0;
    #2 async_rst_n = 1'b0;
    #1;
    check_val("rst_mid_clk", clk_out, 0);
    check_val("rst_mid_active", active, 0);
    #2 async_rst_n = 1'b1;
    tick();
    check_val("restart_rise", rise_event, 1);
    measure_run(1'b1, 1'b0, n, ev);
    check_val("restart_high", n, 2);

    // Randomized run against the reference model
    reset_dut();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      clk_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) gen_en = ~gen_en;
      if ($urandom_range(0, 9) == 0) idle_level = ~idle_level;
      if ($urandom_range(0, 7) == 0) high_rate = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 5));
      if ($urandom_range(0, 7) == 0) low_rate = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 5));
      clear_error = ($urandom_range(0, 19) == 0);
      model_step();
      tick();
      check_val($sformatf("rand%0d_clk", c), clk_out, m_clk);
      check_val($sformatf("rand%0d_rise", c), rise_event, m_rise);
      check_val($sformatf("rand%0d_fall", c), fall_event, m_fall);
      check_val($sformatf("rand%0d_active", c), active, m_run);
      check_val($sformatf("rand%0d_err", c), config_error, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
